// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: shared port indices, data width and statistics width for the data-memory arbiter.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int STATS_W = 16;

  typedef enum logic [0:0] {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef logic [DATA_W-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// dmem_arbiter_if: two requester ports plus the single-ported memory bus.
interface dmem_arbiter_if;
  import mips_pkg::*;

  logic  p0_req;
  logic  p0_we;
  word_t p0_addr;
  word_t p0_wdata;
  logic  p0_gnt;
  logic  p0_rvalid;
  word_t p0_rdata;

  logic  p1_req;
  logic  p1_we;
  word_t p1_addr;
  word_t p1_wdata;
  logic  p1_gnt;
  logic  p1_rvalid;
  word_t p1_rdata;

  word_t mem_address;
  word_t mem_write_data;
  logic  mem_write_enable;
  word_t mem_read_data;

  // Arbiter side: sees requests and memory read data, drives grants and memory controls.
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_read_data,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_address, mem_write_data, mem_write_enable
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_read_data,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_address, mem_write_data, mem_write_enable
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
`default_nettype none
// rr_arbiter2: two-input round-robin grant with a last-granted register.
module rr_arbiter2 import mips_pkg::*; #(
  parameter bit PORT0_FIRST = 1'b1
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic [1:0] req,
  output logic      [1:0] gnt
);

  // Pretending port 1 went last makes port 0 win the first conflict.
  localparam port_e RESET_LAST = PORT0_FIRST ? PORT1 : PORT0;

  port_e last_granted;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_granted == PORT0) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_granted <= RESET_LAST;
    end else if (gnt[PORT1]) begin
      last_granted <= PORT1;
    end else if (gnt[PORT0]) begin
      last_granted <= PORT0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: shares one combinational-read memory between two ports, load latency 1.
// Optional DMEM_ARB_STATS_EN adds a saturating conflict_count output.
module dmem_arbiter import mips_pkg::*; #(
  parameter bit PORT0_FIRST = 1'b1
) (
  input  wire logic        clock,
  input  wire logic        reset,
  dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] conflict_count
`endif
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       load0;
  logic       load1;

  assign req = {bus.p1_req, bus.p0_req};

  rr_arbiter2 #(
    .PORT0_FIRST (PORT0_FIRST)
  ) u_rr_arbiter2 (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.p0_gnt = gnt[PORT0];
  assign bus.p1_gnt = gnt[PORT1];

  always_comb begin
    bus.mem_address      = '0;
    bus.mem_write_data   = '0;
    bus.mem_write_enable = 1'b0;
    if (gnt[PORT0]) begin
      bus.mem_address      = bus.p0_addr;
      bus.mem_write_data   = bus.p0_wdata;
      bus.mem_write_enable = bus.p0_we;
    end else if (gnt[PORT1]) begin
      bus.mem_address      = bus.p1_addr;
      bus.mem_write_data   = bus.p1_wdata;
      bus.mem_write_enable = bus.p1_we;
    end
  end

  assign load0 = gnt[PORT0] & ~bus.p0_we;
  assign load1 = gnt[PORT1] & ~bus.p1_we;

  // rdata holds its value between loads; only rvalid pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
    end else begin
      bus.p0_rvalid <= load0;
      bus.p1_rvalid <= load1;
      if (load0) begin
        bus.p0_rdata <= bus.mem_read_data;
      end
      if (load1) begin
        bus.p1_rdata <= bus.mem_read_data;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_count <= '0;
    end else if ((&req) && (conflict_count != '1)) begin
      conflict_count <= conflict_count + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: directed vector table, randomized traffic against a reference model,
// and a final memory-contents comparison.
module tb_dmem_arbiter;
  import mips_pkg::*;

  localparam bit          P0F = 1'b1;
  localparam bit          H   = 1'b1;
  localparam bit          L   = 1'b0;
  localparam logic [31:0] Z   = 32'h0000_0000;
  localparam logic [31:0] A1  = 32'hA000_0001;
  localparam logic [31:0] A2  = 32'hA000_0002;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;

  typedef struct {
    bit          rst;
    bit          q0;
    bit          w0;
    logic [31:0] a0;
    logic [31:0] d0;
    bit          q1;
    bit          w1;
    logic [31:0] a1;
    logic [31:0] d1;
    bit          g0;
    bit          g1;
    bit          rv0;
    bit          rv1;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_count;
`endif

  dmem_arbiter #(
    .PORT0_FIRST (P0F)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  // Environment memory: untouched words read back as a per-address pattern.
  logic [31:0] mem_arr [64];
  logic [63:0] written = '0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA000_0000 + i;
  endfunction

  assign bus.mem_read_data = written[bus.mem_address[5:0]] ? mem_arr[bus.mem_address[5:0]]
                                                          : init_word(int'(bus.mem_address[5:0]));

  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      mem_arr[bus.mem_address[5:0]] <= bus.mem_write_data;
      written[bus.mem_address[5:0]] <= 1'b1;
    end
  end

  // Reference model state
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          last_g;
  bit          mrv [2];
  logic [31:0] mrd [2];
  logic [31:0] ref_mem [64];
  int          mcnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_g = P0F ? 1 : 0;
    mrv[0] = 1'b0;
    mrv[1] = 1'b0;
    mrd[0] = '0;
    mrd[1] = '0;
    mcnt   = 0;
  endtask

  task automatic run_vec(input vec_t v, input bit use_tbl, output int win);
    bit          e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    rst          = v.rst;
    bus.p0_req   = v.q0;
    bus.p0_we    = v.w0;
    bus.p0_addr  = v.a0;
    bus.p0_wdata = v.d0;
    bus.p1_req   = v.q1;
    bus.p1_we    = v.w1;
    bus.p1_addr  = v.a1;
    bus.p1_wdata = v.d1;
    @(negedge clk);
    if (v.rst)             win = -1;
    else if (v.q0 && v.q1) win = 1 - last_g;
    else if (v.q0)         win = 0;
    else if (v.q1)         win = 1;
    else                   win = -1;
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (win == 0) begin
      e_we = v.w0; e_addr = v.a0; e_wdata = v.d0;
    end else if (win == 1) begin
      e_we = v.w1; e_addr = v.a1; e_wdata = v.d1;
    end
    check("p0_gnt", 32'(bus.p0_gnt), 32'(win == 0));
    check("p1_gnt", 32'(bus.p1_gnt), 32'(win == 1));
    check("mem_write_enable", 32'(bus.mem_write_enable), 32'(e_we));
    check("mem_address", bus.mem_address, e_addr);
    check("mem_write_data", bus.mem_write_data, e_wdata);
    check("p0_rvalid", 32'(bus.p0_rvalid), 32'(mrv[0]));
    check("p1_rvalid", 32'(bus.p1_rvalid), 32'(mrv[1]));
    check("p0_rdata", bus.p0_rdata, mrd[0]);
    check("p1_rdata", bus.p1_rdata, mrd[1]);
`ifdef DMEM_ARB_STATS_EN
    check("conflict_count", 32'(conflict_count), 32'(mcnt));
`endif
    if (use_tbl) begin
      check("tbl_p0_gnt", 32'(bus.p0_gnt), 32'(v.g0));
      check("tbl_p1_gnt", 32'(bus.p1_gnt), 32'(v.g1));
      check("tbl_p0_rvalid", 32'(bus.p0_rvalid), 32'(v.rv0));
      check("tbl_p1_rvalid", 32'(bus.p1_rvalid), 32'(v.rv1));
      check("tbl_p0_rdata", bus.p0_rdata, v.rd0);
      check("tbl_p1_rdata", bus.p1_rdata, v.rd1);
    end
    // Advance the model across the coming posedge.
    if (v.rst) begin
      model_reset();
    end else begin
      mrv[0] = 1'b0;
      mrv[1] = 1'b0;
      if (win >= 0) begin
        last_g = win;
        if (e_we) begin
          ref_mem[e_addr[5:0]] = e_wdata;
        end else begin
          mrv[win] = 1'b1;
          mrd[win] = ref_mem[e_addr[5:0]];
        end
      end
      if (v.q0 && v.q1 && mcnt < 65535) mcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [16];

  initial begin
    int   win;
    vec_t v;
    bit   hold0;
    bit   hold1;

    tbl[0]  = '{H, H,L,32'd1,Z, H,L,32'd2,Z,     L,L,L,L, Z,  Z };
    tbl[1]  = '{L, H,L,32'd1,Z, H,L,32'd2,Z,     H,L,L,L, Z,  Z };
    tbl[2]  = '{L, H,L,32'd1,Z, H,L,32'd2,Z,     L,H,H,L, A1, Z };
    tbl[3]  = '{L, H,L,32'd1,Z, H,L,32'd2,Z,     H,L,L,H, A1, A2};
    tbl[4]  = '{L, H,L,32'd1,Z, H,L,32'd2,Z,     L,H,H,L, A1, A2};
    tbl[5]  = '{L, L,L,Z,Z,     L,L,Z,Z,         L,L,L,H, A1, A2};
    tbl[6]  = '{L, H,H,32'd5,DB, L,L,Z,Z,        H,L,L,L, A1, A2};
    tbl[7]  = '{L, H,L,32'd5,Z, L,L,Z,Z,         H,L,L,L, A1, A2};
    tbl[8]  = '{L, L,L,Z,Z,     L,L,Z,Z,         L,L,H,L, DB, A2};
    tbl[9]  = '{L, H,L,32'd9,Z, H,H,32'd9,32'h11, L,H,L,L, DB, A2};
    tbl[10] = '{L, H,L,32'd9,Z, L,L,Z,Z,         H,L,L,L, DB, A2};
    tbl[11] = '{L, L,L,Z,Z,     L,L,Z,Z,         L,L,H,L, 32'h11, A2};
    tbl[12] = '{H, H,L,32'd3,Z, L,L,Z,Z,         L,L,L,L, 32'h11, A2};
    tbl[13] = '{L, L,L,Z,Z,     L,L,Z,Z,         L,L,L,L, Z,  Z };
    tbl[14] = '{L, H,L,32'd1,Z, H,L,32'd2,Z,     H,L,L,L, Z,  Z };
    tbl[15] = '{L, L,L,Z,Z,     L,L,Z,Z,         L,L,H,L, A1, Z };

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    rst = 1'b1;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 16; i++) run_vec(tbl[i], 1'b1, win);

    // Randomized traffic: pending requests stay stable until granted or withdrawn.
    v     = tbl[13];
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      v.rst = ($urandom_range(0, 59) == 0);
      if (!hold0) begin
        v.q0 = ($urandom_range(0, 2) != 0);
        v.w0 = ($urandom_range(0, 1) == 1);
        v.a0 = $urandom_range(0, 63);
        v.d0 = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        v.q0 = 1'b0;
      end
      if (!hold1) begin
        v.q1 = ($urandom_range(0, 2) != 0);
        v.w1 = ($urandom_range(0, 1) == 1);
        v.a1 = $urandom_range(0, 63);
        v.d1 = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        v.q1 = 1'b0;
      end
      run_vec(v, 1'b0, win);
      hold0 = v.q0 && (win != 0);
      hold1 = v.q1 && (win != 1);
    end

    for (int i = 0; i < 64; i++) begin
      check("mem_contents", written[i] ? mem_arr[i] : init_word(i), ref_mem[i]);
    end

`ifdef DMEM_ARB_STATS_EN
    rst = 1'b1;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("conflict_count_3", 32'(conflict_count), 32'd3);
    repeat (65535) @(posedge clk);
    #1;
    check("conflict_count_sat", 32'(conflict_count), 32'h0000_FFFF);
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter PORT0_FIRST, default 1: 1 = port 0 wins the first conflict after reset; 0 = port 1 wins it.
REQ-002 SHALL have port: clock  input  1  system clock, all state on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports (N = 0, 1): pN_req  input  1  access request; pN_we  input  1  1 = store, 0 = load; pN_addr  input  32  word address; pN_wdata  input  32  store data.
REQ-005 SHALL have ports (N = 0, 1): pN_gnt  output  1  access accepted this cycle; pN_rvalid  output  1  load data valid; pN_rdata  output  32  load data.
REQ-006 SHALL have ports: mem_address  output  32; mem_write_data  output  32; mem_write_enable  output  1; mem_read_data  input  32 (combinational memory read).

Function
REQ-007 SHALL grant at most one port per cycle; pN_gnt is combinational from pN_req and the arbitration state.
REQ-008 SHALL grant a lone requester in the same cycle.
REQ-009 SHALL resolve simultaneous requests round-robin: grant the port not granted most recently.
REQ-010 SHALL update the last-granted register on every grant.
REQ-011 SHALL drive the granted port's addr, wdata and we onto mem_address, mem_write_data and mem_write_enable.
REQ-012 SHALL drive mem_address = 0, mem_write_data = 0 and mem_write_enable = 0 when no port is granted.
REQ-013 SHALL complete a granted store at the same posedge; a store produces no rvalid.
REQ-014 SHALL capture mem_read_data into pN_rdata at the posedge ending a granted load.
REQ-015 SHALL assert pN_rvalid for exactly one cycle after that posedge (load latency 1).
REQ-016 SHALL hold pN_rdata until that port's next load completes.
REQ-017 Requesters SHALL hold req, we, addr and wdata stable until gnt is sampled high; deasserting req before grant withdraws the request with no side effect.
REQ-018 SHALL accept back-to-back grants to one port when the other is idle: one access per cycle, rvalid pipelined behind gnt.
REQ-019 SHALL let a port with rvalid high issue a new request in the same cycle.
REQ-020 SHALL bound the wait of a continuously requesting port to 1 cycle of contention.

Reset
REQ-021 SHALL, while reset is high, force p0_gnt = p1_gnt = 0, mem_write_enable = 0, mem_address = 0 and mem_write_data = 0, regardless of requests.
REQ-022 SHALL clear p0_rvalid, p1_rvalid, p0_rdata and p1_rdata to 0 on the reset edge.
REQ-023 SHALL set last-granted to port 1 on reset when PORT0_FIRST = 1, and to port 0 when PORT0_FIRST = 0.
REQ-024 SHALL discard a load granted in the cycle reset asserts: no rvalid follows.

Configuration
REQ-025 With macro DMEM_ARB_STATS_EN defined, SHALL add output conflict_count (16 bits).
REQ-026 conflict_count SHALL increment on each cycle in which both ports request, saturate at 0xFFFF and clear on reset.
REQ-027 Without DMEM_ARB_STATS_EN, SHALL omit the port and counter, with behaviour otherwise identical.

Structure
REQ-028 SHALL take the port-index constants (PORT0 = 0, PORT1 = 1), the data width (32) and the stats counter width (16) from shared package mips_pkg.
REQ-029 SHALL contain one sub-module, rr_arbiter2: 2-input round-robin grant logic with the last-granted register.

Verification
REQ-030 Port 0 store addr 5, data 0xDEADBEEF, then port 0 load addr 5 -> p0_gnt high both cycles; p0_rvalid one cycle after the load with p0_rdata = 0xDEADBEEF.
REQ-031 Both ports load from reset, addr 1 and 2, held high -> grant order p0, p1, p0, p1 (PORT0_FIRST = 1); each rvalid exactly 1 cycle after its grant.
REQ-032 Port 1 stores 0x11 to addr 9 while port 0 loads addr 9 in the same cycle, after a port-0 grant -> p1 granted first; port 0 granted next; p0_rdata = 0x11.
REQ-033 Reset asserted in the cycle a port-0 load is granted -> p0_rvalid stays 0; p0_rdata = 0; next conflict goes to port 0.
REQ-034 Idle cycles -> mem_write_enable = 0 and mem_address = 0; memory contents unchanged.
REQ-035 With DMEM_ARB_STATS_EN, 3 cycles of dual requests -> conflict_count = 3; with a preset of 0xFFFF -> count stays 0xFFFF.
